// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared opcodes, ALUOp codes and state encodings for the LEGv8 multicycle control
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_R_WB   = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_LD_WB  = 4'd7,
    S_MEM_WR = 4'd8,
    S_CBZ    = 4'd9,
    S_B      = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_R     = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_CBZ   = 3'd4,
    CLS_B     = 3'd5
  } op_class_t;

endpackage

// File: rtl/legv8_opcode_class.sv
// rtl/legv8_opcode_class.sv - combinational opcode classifier used in DECODE
module legv8_opcode_class
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class,
  output logic        legal
);

  // Full-opcode matches win over the prefix matches of CBZ and B.
  always_comb begin
    op_class = CLS_NONE;
    legal    = 1'b1;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
      op_class = CLS_R;
    else if (opcode == OP_LDUR)
      op_class = CLS_LOAD;
    else if (opcode == OP_STUR)
      op_class = CLS_STORE;
    else if (opcode[10:3] == OP_CBZ)
      op_class = CLS_CBZ;
    else if (opcode[10:5] == OP_B)
      op_class = CLS_B;
    else
      legal = 1'b0;
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// rtl/legv8_multicycle_control.sv - main control FSM for the multicycle LEGv8 datapath
module legv8_multicycle_control
  import legv8_pkg::*;
#(
  parameter int OPCODE_W    = 11,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic [1:0]          ALUOp,
  output logic                ALUSrc,
  output logic                Reg2Loc,
  output logic                RegWrite,
  output logic                MemToReg,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCWriteZ,
  output logic                PCSrc,
  output logic [3:0]          state,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                bus_error
);

  localparam logic [TIMEOUT_W-1:0] TMO = TIMEOUT_W'(MEM_TIMEOUT);

  state_t                 state_q, state_d;
  op_class_t              cls_q, op_class;
  logic                   op_legal;
  logic [TIMEOUT_W-1:0]   cnt_q;
  logic                   finish;

  legv8_opcode_class u_class (
    .opcode   (opcode),
    .op_class (op_class),
    .legal    (op_legal)
  );

  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cls_q   <= CLS_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        cls_q <= op_class;
      // Counts only while parked in a data wait state; any exit clears it.
      if ((state_q == S_MEM_RD || state_q == S_MEM_WR) && state_d == state_q)
        cnt_q <= cnt_q + TIMEOUT_W'(1);
      else
        cnt_q <= '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    finish     = 1'b0;
    ALUOp      = ALUOP_ADD;
    ALUSrc     = 1'b0;
    Reg2Loc    = 1'b0;
    RegWrite   = 1'b0;
    MemToReg   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCWriteZ   = 1'b0;
    PCSrc      = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    bus_error  = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!op_legal) begin
          illegal_op = 1'b1;
          finish     = 1'b1;
        end else begin
          case (op_class)
            CLS_R:               state_d = S_EXEC_R;
            CLS_LOAD, CLS_STORE: state_d = S_ADDR;
            CLS_CBZ:             state_d = S_CBZ;
            default:             state_d = S_B;
          endcase
        end
      end
      S_EXEC_R: begin
        ALUOp   = ALUOP_FUNCT;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        finish     = 1'b1;
      end
      S_ADDR: begin
        ALUSrc  = 1'b1;
        Reg2Loc = (cls_q == CLS_STORE);
        state_d = (cls_q == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        if (dmem_ready) begin
          state_d = S_LD_WB;
        end else if (cnt_q == TMO) begin
          bus_error = 1'b1;
          finish    = 1'b1;
        end
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        if (dmem_ready) begin
          instr_done = 1'b1;
          finish     = 1'b1;
        end else if (cnt_q == TMO) begin
          bus_error = 1'b1;
          finish    = 1'b1;
        end
      end
      S_LD_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
        finish     = 1'b1;
      end
      S_CBZ: begin
        ALUOp      = ALUOP_PASSB;
        Reg2Loc    = 1'b1;
        PCWriteZ   = 1'b1;
        PCSrc      = 1'b1;
        instr_done = 1'b1;
        finish     = 1'b1;
      end
      S_B: begin
        PCWrite    = 1'b1;
        PCSrc      = 1'b1;
        instr_done = 1'b1;
        finish     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (finish)
      state_d = run ? S_FETCH : S_IDLE;
  end

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// tb/tb_legv8_multicycle_control.sv - scoreboard bench for the LEGv8 multicycle control FSM
module tb_legv8_multicycle_control;

  logic        clk = 1'b0;
  logic        reset, run, imem_ready, dmem_ready;
  logic [10:0] opcode;
  logic [1:0]  ALUOp;
  logic        ALUSrc, Reg2Loc, RegWrite, MemToReg, MemRead, MemWrite;
  logic        IRWrite, PCWrite, PCWriteZ, PCSrc, instr_done, illegal_op, bus_error;
  logic [3:0]  state;

  legv8_multicycle_control #(.OPCODE_W(11), .TIMEOUT_W(8), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteZ(PCWriteZ), .PCSrc(PCSrc), .state(state),
    .instr_done(instr_done), .illegal_op(illegal_op), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  localparam logic [10:0] BR   = 11'b00010110110;
  localparam logic [10:0] BAD  = 11'b11111111111;
  localparam logic [10:0] X    = 11'b00000000000;

  localparam logic [12:0] F_ALUSRC = 13'h1000, F_REG2LOC = 13'h0800, F_REGW  = 13'h0400;
  localparam logic [12:0] F_M2R    = 13'h0200, F_MRD     = 13'h0100, F_MWR   = 13'h0080;
  localparam logic [12:0] F_IRW    = 13'h0040, F_PCW     = 13'h0020, F_PCWZ  = 13'h0010;
  localparam logic [12:0] F_PCSRC  = 13'h0008, F_DONE    = 13'h0004, F_ILL   = 13'h0002;
  localparam logic [12:0] F_BERR   = 13'h0001;

  typedef struct {
    string       name;
    logic [18:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          tests = 0;
  int          failures = 0;
  logic [18:0] obs;

  assign obs = {state, ALUOp, ALUSrc, Reg2Loc, RegWrite, MemToReg, MemRead, MemWrite,
                IRWrite, PCWrite, PCWriteZ, PCSrc, instr_done, illegal_op, bus_error};

  task automatic step(input string name, input logic r, input logic rn, input logic im,
                      input logic dm, input logic [10:0] op, input logic [3:0] st,
                      input logic [1:0] aop, input logic [12:0] fl);
    exp_t e;
    #1;
    reset = r; run = rn; imem_ready = im; dmem_ready = dm; opcode = op;
    e.name = name;
    e.v    = {st, aop, fl};
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      tests++;
      if (obs !== cur.v) begin
        failures++;
        $display("FAIL %s: got state=%0d outs=%b required state=%0d outs=%b",
                 cur.name, obs[18:15], obs[14:0], cur.v[18:15], cur.v[14:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = X;
    @(posedge clk);
    step("rst0",        1, 0, 0, 0, X,    0, 2'b00, 0);
    step("rst1",        1, 0, 0, 0, X,    0, 2'b00, 0);
    step("idle_run",    0, 1, 1, 1, X,    0, 2'b00, 0);
    // ADD, one cycle of fetch hold first
    step("add_hold",    0, 1, 0, 1, X,    1, 2'b00, 0);
    step("add_fetch",   0, 1, 1, 1, X,    1, 2'b00, F_IRW | F_PCW);
    step("add_dec",     0, 1, 1, 1, ADD,  2, 2'b00, 0);
    step("add_exec",    0, 1, 1, 1, ADD,  3, 2'b10, 0);
    step("add_wb",      0, 1, 1, 1, ADD,  4, 2'b00, F_REGW | F_DONE);
    // LDUR, ready after 3 waits
    step("ld_fetch",    0, 1, 1, 1, X,    1, 2'b00, F_IRW | F_PCW);
    step("ld_dec",      0, 1, 1, 1, LDUR, 2, 2'b00, 0);
    step("ld_addr",     0, 1, 1, 1, LDUR, 5, 2'b00, F_ALUSRC);
    step("ld_wait0",    0, 1, 1, 0, LDUR, 6, 2'b00, F_MRD);
    step("ld_wait1",    0, 1, 1, 0, LDUR, 6, 2'b00, F_MRD);
    step("ld_wait2",    0, 1, 1, 0, LDUR, 6, 2'b00, F_MRD);
    step("ld_ready",    0, 1, 1, 1, LDUR, 6, 2'b00, F_MRD);
    step("ld_wb",       0, 1, 1, 1, LDUR, 7, 2'b00, F_REGW | F_M2R | F_DONE);
    // STUR, memory never ready: timeout at count 4
    step("st_fetch",    0, 1, 1, 0, X,    1, 2'b00, F_IRW | F_PCW);
    step("st_dec",      0, 1, 1, 0, STUR, 2, 2'b00, 0);
    step("st_addr",     0, 1, 1, 0, STUR, 5, 2'b00, F_ALUSRC | F_REG2LOC);
    step("st_wait0",    0, 1, 1, 0, STUR, 8, 2'b00, F_MWR);
    step("st_wait1",    0, 1, 1, 0, STUR, 8, 2'b00, F_MWR);
    step("st_wait2",    0, 1, 1, 0, STUR, 8, 2'b00, F_MWR);
    step("st_wait3",    0, 1, 1, 0, STUR, 8, 2'b00, F_MWR);
    step("st_timeout",  0, 1, 1, 0, STUR, 8, 2'b00, F_MWR | F_BERR);
    // CBZ then B
    step("cbz_fetch",   0, 1, 1, 1, X,    1, 2'b00, F_IRW | F_PCW);
    step("cbz_dec",     0, 1, 1, 1, CBZ,  2, 2'b00, 0);
    step("cbz_exec",    0, 1, 1, 1, CBZ,  9, 2'b01, F_REG2LOC | F_PCWZ | F_PCSRC | F_DONE);
    step("b_fetch",     0, 1, 1, 1, X,    1, 2'b00, F_IRW | F_PCW);
    step("b_dec",       0, 1, 1, 1, BR,   2, 2'b00, 0);
    step("b_exec",      0, 1, 1, 1, BR,  10, 2'b00, F_PCW | F_PCSRC | F_DONE);
    // illegal opcode, then zero-wait STUR and SUB
    step("ill_fetch",   0, 1, 1, 1, X,    1, 2'b00, F_IRW | F_PCW);
    step("ill_dec",     0, 1, 1, 1, BAD,  2, 2'b00, F_ILL);
    step("st0_fetch",   0, 1, 1, 1, X,    1, 2'b00, F_IRW | F_PCW);
    step("st0_dec",     0, 1, 1, 1, STUR, 2, 2'b00, 0);
    step("st0_addr",    0, 1, 1, 1, STUR, 5, 2'b00, F_ALUSRC | F_REG2LOC);
    step("st0_wr",      0, 1, 1, 1, STUR, 8, 2'b00, F_MWR | F_DONE);
    step("sub_fetch",   0, 1, 1, 1, X,    1, 2'b00, F_IRW | F_PCW);
    step("sub_dec",     0, 1, 1, 1, SUB,  2, 2'b00, 0);
    step("sub_exec",    0, 1, 1, 1, SUB,  3, 2'b10, 0);
    step("sub_wb",      0, 1, 1, 1, SUB,  4, 2'b00, F_REGW | F_DONE);
    // run dropped during LDUR: completes, then IDLE
    step("rd_fetch",    0, 1, 1, 1, X,    1, 2'b00, F_IRW | F_PCW);
    step("rd_dec",      0, 0, 1, 1, LDUR, 2, 2'b00, 0);
    step("rd_addr",     0, 0, 1, 1, LDUR, 5, 2'b00, F_ALUSRC);
    step("rd_wait",     0, 0, 1, 0, LDUR, 6, 2'b00, F_MRD);
    step("rd_ready",    0, 0, 1, 1, LDUR, 6, 2'b00, F_MRD);
    step("rd_wb",       0, 0, 1, 1, LDUR, 7, 2'b00, F_REGW | F_M2R | F_DONE);
    step("rd_idle0",    0, 0, 1, 1, X,    0, 2'b00, 0);
    step("rd_idle1",    0, 0, 1, 1, X,    0, 2'b00, 0);
    // reset asserted while MemRead is high
    step("rm_idle",     0, 1, 1, 1, X,    0, 2'b00, 0);
    step("rm_fetch",    0, 1, 1, 1, X,    1, 2'b00, F_IRW | F_PCW);
    step("rm_dec",      0, 1, 1, 1, LDUR, 2, 2'b00, 0);
    step("rm_addr",     0, 1, 1, 0, LDUR, 5, 2'b00, F_ALUSRC);
    step("rm_wait",     0, 1, 1, 0, LDUR, 6, 2'b00, F_MRD);
    step("rm_reset",    1, 1, 1, 0, LDUR, 0, 2'b00, 0);
    step("rm_restart",  0, 1, 1, 0, X,    0, 2'b00, 0);
    step("rm_fetch2",   0, 1, 1, 0, X,    1, 2'b00, F_IRW | F_PCW);
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
